// File: rtl/dec_pkg.sv
// Shared decimal-unit constants: digit width, radix and the sequencer state encoding.
package dec_pkg;

   localparam int unsigned DIGIT_W   = 4;
   localparam int unsigned BCD_RADIX = 10;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/dec_sub_digit.sv
// Single BCD digit subtract cell: d = a - b - bin with radix-10 correction on borrow.
module dec_sub_digit
   import dec_pkg::*;
(
   input  logic [DIGIT_W-1:0] a,
   input  logic [DIGIT_W-1:0] b,
   input  logic               bin,
   output logic [DIGIT_W-1:0] d,
   output logic               bout,
   output logic               invalid
);

   logic [DIGIT_W:0] t;

   // 5-bit two's complement difference; the top bit is the sign
   always_comb begin
      t       = {1'b0, a} - {1'b0, b} - {{DIGIT_W{1'b0}}, bin};
      bout    = t[DIGIT_W];
      d       = bout ? (t[DIGIT_W-1:0] + DIGIT_W'(BCD_RADIX)) : t[DIGIT_W-1:0];
      invalid = (a > DIGIT_W'(BCD_RADIX - 1)) || (b > DIGIT_W'(BCD_RADIX - 1));
   end

endmodule

// File: rtl/dec_sub_serial.sv
// Digit-serial BCD subtractor, LSD first, start/busy/done handshake.
// Optional non-BCD input detection enabled by defining DEC_SUB_INVALID_CHECK_EN.
module dec_sub_serial
   import dec_pkg::*;
#(
   parameter int unsigned DIGITS = 4
)
(
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        start,
   input  logic [DIGIT_W*DIGITS-1:0]   num1,
   input  logic [DIGIT_W*DIGITS-1:0]   num2,
   input  logic                        b_in,
   output logic                        busy,
   output logic                        done,
   output logic [DIGIT_W*DIGITS-1:0]   diff,
   output logic                        b_out,
   output logic                        err
);

   localparam int unsigned W  = DIGIT_W * DIGITS;
   localparam int unsigned CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   logic [1:0]         state_q,  state_d;
   logic [CW-1:0]      cnt_q,    cnt_d;
   logic [W-1:0]       a_q,      a_d;
   logic [W-1:0]       b_q,      b_d;
   logic               borrow_q, borrow_d;
   logic [W-1:0]       diff_q,   diff_d;
   logic               bout_q,   bout_d;

   logic [DIGIT_W-1:0] dig_a, dig_b, dig_d;
   logic               dig_bout, dig_invalid;

   always_comb begin
      dig_a = a_q[DIGIT_W*cnt_q +: DIGIT_W];
      dig_b = b_q[DIGIT_W*cnt_q +: DIGIT_W];
   end

   dec_sub_digit u_digit (
      .a       (dig_a),
      .b       (dig_b),
      .bin     (borrow_q),
      .d       (dig_d),
      .bout    (dig_bout),
      .invalid (dig_invalid)
   );

`ifdef DEC_SUB_INVALID_CHECK_EN
   logic err_q, err_d;
   assign err = err_q;
`else
   logic unused_invalid;
   assign unused_invalid = dig_invalid;
   assign err            = 1'b0;
`endif

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      a_d      = a_q;
      b_d      = b_q;
      borrow_d = borrow_q;
      diff_d   = diff_q;
      bout_d   = bout_q;
`ifdef DEC_SUB_INVALID_CHECK_EN
      err_d    = err_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d  = ST_RUN;
               a_d      = num1;
               b_d      = num2;
               cnt_d    = '0;
               borrow_d = b_in;
               diff_d   = '0;
               bout_d   = 1'b0;
`ifdef DEC_SUB_INVALID_CHECK_EN
               err_d    = 1'b0;
`endif
            end
         end
         ST_RUN: begin
            diff_d[DIGIT_W*cnt_q +: DIGIT_W] = dig_d;
            borrow_d = dig_bout;
`ifdef DEC_SUB_INVALID_CHECK_EN
            err_d    = err_q | dig_invalid;
`endif
            // Counter parks on the last digit rather than wrapping
            if (cnt_q == CW'(DIGITS - 1)) begin
               state_d = ST_DONE;
               bout_d  = dig_bout;
            end else begin
               cnt_d   = cnt_q + 1'b1;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         borrow_q <= 1'b0;
         diff_q   <= '0;
         bout_q   <= 1'b0;
`ifdef DEC_SUB_INVALID_CHECK_EN
         err_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         a_q      <= a_d;
         b_q      <= b_d;
         borrow_q <= borrow_d;
         diff_q   <= diff_d;
         bout_q   <= bout_d;
`ifdef DEC_SUB_INVALID_CHECK_EN
         err_q    <= err_d;
`endif
      end
   end

   assign busy  = (state_q != ST_IDLE);
   assign done  = (state_q == ST_DONE);
   assign diff  = diff_q;
   assign b_out = bout_q;

endmodule

// File: tb/tb_dec_sub_serial.sv
// Self-checking bench for dec_sub_serial: vector table + scoreboard, DIGITS=4 and DIGITS=1 instances.
module tb_dec_sub_serial;

   localparam int unsigned D = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [15:0] num1 = '0, num2 = '0;
   logic        b_in = 1'b0;
   logic        busy, done, b_out, err;
   logic [15:0] diff;

   logic        start1 = 1'b0;
   logic [3:0]  n1_1 = '0, n2_1 = '0;
   logic        busy1, done1, bout1, err1;
   logic [3:0]  diff1;

   always #5 clk = ~clk;

   dec_sub_serial #(.DIGITS(D)) dut (
      .clk(clk), .rst(rst), .start(start), .num1(num1), .num2(num2), .b_in(b_in),
      .busy(busy), .done(done), .diff(diff), .b_out(b_out), .err(err)
   );

   dec_sub_serial #(.DIGITS(1)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .num1(n1_1), .num2(n2_1), .b_in(1'b0),
      .busy(busy1), .done(done1), .diff(diff1), .b_out(bout1), .err(err1)
   );

   typedef struct packed {
      logic [15:0] diff;
      logic        bout;
      logic        err;
      logic        chk_val;
   } exp_t;

   typedef struct packed {
      logic [15:0] n1;
      logic [15:0] n2;
      logic        bin;
      logic [15:0] diff;
      logic        bout;
   } vec_t;

   exp_t sbq[$];
   int   vectors = 0;
   int   miscompares = 0;
   int   done_cnt = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic int bcd2int(input logic [15:0] v);
      int r = 0;
      for (int i = 3; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
      return r;
   endfunction

   function automatic logic [15:0] int2bcd(input int v);
      logic [15:0] r = '0;
      for (int i = 0; i < 4; i++) begin
         r[4*i +: 4] = 4'(v % 10);
         v = v / 10;
      end
      return r;
   endfunction

   // Scoreboard monitor for the DIGITS=4 instance
   always @(negedge clk) begin
      if (done) begin
         done_cnt++;
         if (sbq.size() == 0) begin
            chk("unexpected_done", 32'(done), 32'd0);
         end else begin
            exp_t e;
            e = sbq.pop_front();
            if (e.chk_val) begin
               chk("sb_diff", 32'(diff), 32'(e.diff));
               chk("sb_bout", 32'(b_out), 32'(e.bout));
            end
            chk("sb_err", 32'(err), 32'(e.err));
         end
      end
   end

   task automatic run_op(input logic [15:0] n1, input logic [15:0] n2, input logic bi,
                         input exp_t e);
      @(negedge clk);
      num1 = n1; num2 = n2; b_in = bi; start = 1'b1;
      sbq.push_back(e);
      @(posedge clk); #1;
      start = 1'b0;
      num1 = 16'($urandom); num2 = 16'($urandom); b_in = ~bi;
      chk("busy_after_start", 32'(busy), 32'd1);
      chk("no_early_done", 32'(done), 32'd0);
      repeat (D - 1) @(posedge clk);
      #1 chk("done_before_last", 32'(done), 32'd0);
      @(posedge clk); #1;
      chk("done_latency", 32'(done), 32'd1);
      @(posedge clk); #1;
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_done", 32'(done), 32'd0);
   endtask

   vec_t tbl[8];
   exp_t e;
   int   dc;

   initial begin
      tbl[0] = '{16'h4321, 16'h1234, 1'b0, 16'h3087, 1'b0};
      tbl[1] = '{16'h0000, 16'h0001, 1'b0, 16'h9999, 1'b1};
      tbl[2] = '{16'h1000, 16'h0999, 1'b1, 16'h0000, 1'b0};
      tbl[3] = '{16'h9999, 16'h9999, 1'b1, 16'h9999, 1'b1};
      tbl[4] = '{16'h9999, 16'h0000, 1'b0, 16'h9999, 1'b0};
      tbl[5] = '{16'h0500, 16'h0499, 1'b0, 16'h0001, 1'b0};
      tbl[6] = '{16'h1234, 16'h4321, 1'b0, 16'h6913, 1'b1};
      tbl[7] = '{16'h0000, 16'h0000, 1'b1, 16'h9999, 1'b1};

      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_diff", 32'(diff), 32'd0);
      chk("rst_bout", 32'(b_out), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_busy1", 32'(busy1), 32'd0);
      @(negedge clk) rst = 1'b0;

      for (int i = 0; i < 8; i++) begin
         e = '{tbl[i].diff, tbl[i].bout, 1'b0, 1'b1};
         run_op(tbl[i].n1, tbl[i].n2, tbl[i].bin, e);
      end

      // Randomised BCD operands checked against an integer model
      for (int i = 0; i < 10; i++) begin
         logic [15:0] a, b;
         logic        bi;
         int          r;
         for (int k = 0; k < 4; k++) begin
            a[4*k +: 4] = 4'($urandom_range(0, 9));
            b[4*k +: 4] = 4'($urandom_range(0, 9));
         end
         bi = 1'($urandom_range(0, 1));
         r  = bcd2int(a) - bcd2int(b) - int'(bi);
         e  = '{int2bcd(r < 0 ? r + 10000 : r), r < 0, 1'b0, 1'b1};
         run_op(a, b, bi, e);
      end

      // Result hold while idle with inputs changing
      repeat (5) begin
         @(negedge clk);
         num1 = 16'($urandom); num2 = 16'($urandom);
      end
      chk("hold_diff", 32'(diff), 32'(e.diff));
      chk("hold_bout", 32'(b_out), 32'(e.bout));

      // start held high through RUN/DONE must not queue a second op
      dc = done_cnt;
      @(negedge clk);
      num1 = 16'h5000; num2 = 16'h0001; b_in = 1'b0; start = 1'b1;
      sbq.push_back('{16'h4999, 1'b0, 1'b0, 1'b1});
      @(posedge clk);
      repeat (D) @(posedge clk);
      #1 start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk("single_done", 32'(done_cnt - dc), 32'd1);
      chk("sb_empty_after_hold_start", 32'(sbq.size()), 32'd0);
      chk("held_diff", 32'(diff), 32'h4999);

      // rst mid-RUN aborts with no done
      dc = done_cnt;
      @(negedge clk);
      num1 = 16'h5000; num2 = 16'h0001; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      @(posedge clk);
      @(negedge clk) rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_diff", 32'(diff), 32'd0);
      chk("abort_bout", 32'(b_out), 32'd0);
      repeat (D + 3) @(posedge clk);
      #1 chk("abort_no_done", 32'(done_cnt - dc), 32'd0);

`ifdef DEC_SUB_INVALID_CHECK_EN
      run_op(16'h00A0, 16'h0000, 1'b0, '{16'h0000, 1'b0, 1'b1, 1'b0});
`else
      run_op(16'h00A0, 16'h0000, 1'b0, '{16'h0000, 1'b0, 1'b0, 1'b0});
`endif
      run_op(16'h0010, 16'h0005, 1'b0, '{16'h0005, 1'b0, 1'b0, 1'b1});

      // DIGITS=1 instance: 3 - 7 wraps to 6 with borrow
      @(negedge clk);
      n1_1 = 4'h3; n2_1 = 4'h7; start1 = 1'b1;
      @(posedge clk); #1;
      start1 = 1'b0;
      chk("d1_busy", 32'(busy1), 32'd1);
      chk("d1_no_early_done", 32'(done1), 32'd0);
      @(posedge clk); #1;
      chk("d1_done", 32'(done1), 32'd1);
      chk("d1_diff", 32'(diff1), 32'h6);
      chk("d1_bout", 32'(bout1), 32'd1);
      chk("d1_err", 32'(err1), 32'd0);
      @(posedge clk); #1;
      chk("d1_idle", 32'(busy1), 32'd0);

      repeat (2) @(posedge clk);
      #1 chk("sb_drained", 32'(sbq.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
